// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU, with a single-entry response register (ALU_ARBITER_FIXED_PRIO_EN selects fixed priority).
// Latency: one cycle from grant to rsp_valid; drain and refill in the same cycle, so there are no bubbles.
// Backpressure: while the response is held and rsp_ready=0, no grant is issued and rsp_* stay stable.
module alu_arbiter #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_ctrl,
  input  logic [D_WIDTH-1:0] req0_a,
  input  logic [D_WIDTH-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_ctrl,
  input  logic [D_WIDTH-1:0] req1_a,
  input  logic [D_WIDTH-1:0] req1_b,
  output logic [3:0]         alu_ctrl,
  output logic [D_WIDTH-1:0] alu_src_a,
  output logic [D_WIDTH-1:0] alu_src_b,
  input  logic [D_WIDTH-1:0] alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [D_WIDTH-1:0] rsp_result,
  output logic               rsp_zero
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [D_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 can_accept;
  logic                 grant;
  logic                 sel1;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  logic                 last_grant_q, last_grant_d;
`endif

  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    grant      = can_accept && (req0_valid || req1_valid) && !rst;

    // Winner on conflict: fixed priority favours req0, round-robin favours whoever did not win last.
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      sel1 = 1'b0;
`else
      sel1 = ~last_grant_q;
`endif
    end else begin
      sel1 = req1_valid;
    end

    req0_ready = grant && !sel1;
    req1_ready = grant && sel1;

    alu_ctrl  = 4'b0000;
    alu_src_a = '0;
    alu_src_b = '0;
    if (grant) begin
      alu_ctrl  = sel1 ? req1_ctrl : req0_ctrl;
      alu_src_a = sel1 ? req1_a    : req0_a;
      alu_src_b = sel1 ? req1_b    : req0_b;
    end

    state_d      = state_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    if (grant) begin
      state_d      = FULL;
      rsp_id_d     = sel1;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end

`ifndef ALU_ARBITER_FIXED_PRIO_EN
    last_grant_d = grant ? sel1 : last_grant_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule
